// File: rtl/phv_sched_pkg.sv
// Shared types and helpers for the PHV queue scheduler: FSM state encoding,
// index-width helper and the round-robin pointer wrap.
package phv_sched_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_IDLE  = 2'd2
    } sched_state_t;

    localparam int CNT_W_DEF = 32;

    function automatic int qid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Pointer position just after the granted queue, wrapping to 0.
    function automatic int ptr_wrap(input int grant, input int n);
        return (grant >= n - 1) ? 0 : grant + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin priority pick: first set req bit at or after ptr, wrapping.
// Latency: combinational. Backpressure: none (pure function of req/ptr).
module rr_arbiter_n #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int idx;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        any     = |req;
        idx     = 0;
        for (int off = N - 1; off >= 0; off--) begin
            idx = int'(ptr) + off;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                gnt_oh      = '0;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/phv_queue_scheduler.sv
// Round-robin share of one PHV output among per-queue sources; optional PHV_SCHED_STATS_EN grant counters.
// Latency: 1 cycle in->out, 1 PHV/cycle when downstream ready stays high.
// Backpressure: no grant while output holds an unaccepted PHV or when paused; output held stable on stall.
module phv_queue_scheduler
    import phv_sched_pkg::*;
#(
    parameter int PHV_LEN      = 1024,
    parameter int C_NUM_QUEUES = 4,
`ifdef PHV_SCHED_STATS_EN
    parameter int CNT_W        = CNT_W_DEF,
`endif
    localparam int QID_W       = qid_width(C_NUM_QUEUES)
) (
    input  logic                            axis_clk,
    input  logic                            areset,
    input  logic [PHV_LEN*C_NUM_QUEUES-1:0] phv_in,
    input  logic [C_NUM_QUEUES-1:0]         phv_in_valid,
    output logic [C_NUM_QUEUES-1:0]         phv_in_ready,
    output logic [PHV_LEN-1:0]              phv_out,
    output logic [QID_W-1:0]                phv_out_qid,
    output logic                            phv_out_valid,
    input  logic                            phv_out_ready,
    input  logic [C_NUM_QUEUES-1:0]         cfg_q_mask,
    input  logic                            cfg_pause,
    output logic                            pause_ack
`ifdef PHV_SCHED_STATS_EN
    ,
    output logic [CNT_W*C_NUM_QUEUES-1:0]   grant_cnt
`endif
);

    sched_state_t              state_q, state_d;
    logic [QID_W-1:0]          ptr_q, ptr_d;
    logic [QID_W-1:0]          qid_q, qid_d;
    logic [PHV_LEN-1:0]        out_q, out_d;
    logic                      vld_q, vld_d;
    logic                      ack_q, ack_d;

    logic [C_NUM_QUEUES-1:0]   req;
    logic [C_NUM_QUEUES-1:0]   gnt_oh;
    logic [QID_W-1:0]          gnt_idx;
    logic                      any;
    logic                      slot_free;
    logic                      load;

    assign req       = phv_in_valid & cfg_q_mask;
    assign slot_free = !vld_q || phv_out_ready;
    // Reset also masks ready so no source pops while the block is held in reset.
    assign load      = (state_q == ST_RUN) && slot_free && any && !areset;

    rr_arbiter_n #(
        .N     (C_NUM_QUEUES),
        .IDX_W (QID_W)
    ) u_arb (
        .req     (req),
        .ptr     (ptr_q),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign phv_in_ready  = gnt_oh & {C_NUM_QUEUES{load}};
    assign phv_out       = out_q;
    assign phv_out_qid   = qid_q;
    assign phv_out_valid = vld_q;
    assign pause_ack     = ack_q;

    always_comb begin
        out_d = out_q;
        qid_d = qid_q;
        vld_d = vld_q;
        ptr_d = ptr_q;
        if (load) begin
            out_d = phv_in[int'(gnt_idx)*PHV_LEN +: PHV_LEN];
            qid_d = gnt_idx;
            vld_d = 1'b1;
            ptr_d = QID_W'(ptr_wrap(int'(gnt_idx), C_NUM_QUEUES));
        end else if (phv_out_ready) begin
            vld_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   if (cfg_pause) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (!cfg_pause) begin
                    state_d = ST_RUN;
                end else if (slot_free) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE:  if (!cfg_pause) state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase
        // Computed from next-state values so the flop tracks the current state/valid pair.
        ack_d = (state_d == ST_IDLE) && !vld_d;
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            state_q <= ST_RUN;
            ptr_q   <= '0;
            qid_q   <= '0;
            out_q   <= '0;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            qid_q   <= qid_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
        end
    end

`ifdef PHV_SCHED_STATS_EN
    logic [C_NUM_QUEUES-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d[gnt_idx] = cnt_q[gnt_idx] + CNT_W'(1);
        end
    end

    always_ff @(posedge axis_clk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign grant_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_phv_queue_scheduler.sv
// Randomised bench for phv_queue_scheduler: reference model of sources, RR pointer and pause FSM,
// with a scoreboard of expected PHVs popped by an independent output monitor.
module tb_phv_queue_scheduler;

    localparam int N  = 4;
    localparam int PL = 1024;
    localparam int QW = 2;

    logic              axis_clk;
    logic              areset;
    logic [PL*N-1:0]   phv_in;
    logic [N-1:0]      phv_in_valid;
    logic [N-1:0]      phv_in_ready;
    logic [PL-1:0]     phv_out;
    logic [QW-1:0]     phv_out_qid;
    logic              phv_out_valid;
    logic              phv_out_ready;
    logic [N-1:0]      cfg_q_mask;
    logic              cfg_pause;
    logic              pause_ack;
`ifdef PHV_SCHED_STATS_EN
    logic [32*N-1:0]   grant_cnt;
`endif

    phv_queue_scheduler dut (
        .axis_clk      (axis_clk),
        .areset        (areset),
        .phv_in        (phv_in),
        .phv_in_valid  (phv_in_valid),
        .phv_in_ready  (phv_in_ready),
        .phv_out       (phv_out),
        .phv_out_qid   (phv_out_qid),
        .phv_out_valid (phv_out_valid),
        .phv_out_ready (phv_out_ready),
        .cfg_q_mask    (cfg_q_mask),
        .cfg_pause     (cfg_pause),
        .pause_ack     (pause_ack)
`ifdef PHV_SCHED_STATS_EN
        ,
        .grant_cnt     (grant_cnt)
`endif
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [PL-1:0] act, input logic [PL-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 128 bits) at %0t", nm, act[127:0], exp[127:0], $time);
        end
    endtask

    // Source model: one pending PHV per queue, held until the scheduler pops it.
    bit            src_vld [N];
    logic [PL-1:0] src_dat [N];

    // Scheduler reference model.
    int  m_ptr;
    int  m_state;     // 0 run, 1 drain, 2 idle
    bit  m_vld;
    bit  m_load;
    int  m_grant;
    bit  m_pause;
    bit  m_ordy;
    int  m_cnt [N];

    logic [PL-1:0] exp_dat [$];
    int            exp_qid [$];

    function automatic logic [PL-1:0] rand_phv();
        logic [PL-1:0] r;
        r = '0;
        for (int w = 0; w < PL / 32; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic model_edge();
        int ns;
        ns = m_state;
        case (m_state)
            0: if (m_pause) ns = 1;
            1: if (!m_pause) ns = 0; else if (!m_vld || m_ordy) ns = 2;
            2: if (!m_pause) ns = 0;
            default: ns = 0;
        endcase
        if (m_load) begin
            m_vld = 1'b1;
            m_ptr = (m_grant + 1) % N;
            src_vld[m_grant] = 1'b0;
            m_cnt[m_grant]++;
        end else if (m_ordy) begin
            m_vld = 1'b0;
        end
        m_state = ns;
        m_load  = 1'b0;
    endtask

    task automatic cycle(input int fill_pct, input logic [N-1:0] fill_mask, input int mask_sel,
                         input int rdy_pct, input int pause_sel);
        logic [N-1:0] req;
        logic [N-1:0] exp_rdy;
        bit found;
        @(posedge axis_clk);
        model_edge();
        #1;
        for (int i = 0; i < N; i++) begin
            if (!src_vld[i] && fill_mask[i] && ($urandom_range(99) < fill_pct)) begin
                src_vld[i] = 1'b1;
                src_dat[i] = rand_phv();
            end
            phv_in_valid[i]          = src_vld[i];
            phv_in[i*PL +: PL]       = src_dat[i];
        end
        if (mask_sel < 0) cfg_q_mask = N'($urandom);
        else              cfg_q_mask = N'(mask_sel);
        phv_out_ready = ($urandom_range(99) < rdy_pct);
        if (pause_sel == 2) begin
            if ($urandom_range(19) == 0) cfg_pause = !cfg_pause;
        end else begin
            cfg_pause = (pause_sel != 0);
        end
        m_pause = cfg_pause;
        m_ordy  = phv_out_ready;
        #1;
        req = '0;
        for (int i = 0; i < N; i++) req[i] = src_vld[i] && cfg_q_mask[i];
        found = 1'b0;
        if (m_state == 0 && (!m_vld || m_ordy)) begin
            for (int k = 0; k < N; k++) begin
                if (!found && req[(m_ptr + k) % N]) begin
                    found   = 1'b1;
                    m_grant = (m_ptr + k) % N;
                end
            end
        end
        m_load  = found;
        exp_rdy = '0;
        if (m_load) exp_rdy[m_grant] = 1'b1;
        chk("in_ready", phv_in_ready, exp_rdy);
        chk("out_valid", phv_out_valid, m_vld);
        chk("pause_ack", pause_ack, (m_state == 2) && !m_vld);
        if (m_vld && exp_qid.size() > 0) begin
            chk("out_hold_dat", phv_out, exp_dat[0]);
            chk("out_hold_qid", phv_out_qid, exp_qid[0]);
        end
        if (m_load) begin
            exp_dat.push_back(src_dat[m_grant]);
            exp_qid.push_back(m_grant);
        end
    endtask

    task automatic do_reset();
        @(posedge axis_clk);
        model_edge();
        #3;
        areset       = 1'b1;
        phv_in_valid = '0;
        cfg_pause    = 1'b0;
        #1;
        chk("rst_out_valid", phv_out_valid, 0);
        chk("rst_in_ready", phv_in_ready, 0);
        chk("rst_pause_ack", pause_ack, 0);
        chk("rst_out_dat", phv_out, 0);
        chk("rst_out_qid", phv_out_qid, 0);
        m_vld = 0; m_ptr = 0; m_state = 0; m_load = 0; m_pause = 0; m_ordy = 0;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
        exp_dat.delete();
        exp_qid.delete();
        repeat (2) @(posedge axis_clk);
        #3 areset = 1'b0;
    endtask

    // Output monitor: every accepted PHV must match the oldest expected grant.
    always @(negedge axis_clk) begin
        if (!areset && phv_out_valid && phv_out_ready) begin
            if (exp_qid.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL out_unexpected: got qid %0d expected no output at %0t", phv_out_qid, $time);
            end else begin
                chk("out_dat", phv_out, exp_dat.pop_front());
                chk("out_qid", phv_out_qid, exp_qid.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        areset = 1'b1; phv_in = '0; phv_in_valid = '0; phv_out_ready = 1'b0;
        cfg_q_mask = '0; cfg_pause = 1'b0;
        m_ptr = 0; m_state = 0; m_vld = 0; m_load = 0; m_grant = 0; m_pause = 0; m_ordy = 0;
        for (int i = 0; i < N; i++) begin
            src_vld[i] = 1'b0; src_dat[i] = '0; m_cnt[i] = 0;
        end
        #2;
        chk("init_out_valid", phv_out_valid, 0);
        chk("init_in_ready", phv_in_ready, 0);
        chk("init_pause_ack", pause_ack, 0);
        chk("init_out_dat", phv_out, 0);
        chk("init_out_qid", phv_out_qid, 0);
        repeat (2) @(posedge axis_clk);
        #3 areset = 1'b0;

        repeat (4)  cycle(100, 4'b0100, 4'hF, 100, 0);   // lone q2 regranted via pointer wrap
        repeat (12) cycle(100, 4'hF,   4'hF, 100, 0);    // full rotation, 1 PHV/cycle
        repeat (12) cycle(100, 4'hF,   4'hB, 100, 0);    // masked q2 skipped
        repeat (5)  cycle(100, 4'hF,   4'hF, 0,   0);    // downstream stall
        repeat (3)  cycle(100, 4'hF,   4'hF, 100, 0);
        repeat (3)  cycle(100, 4'hF,   4'hF, 0,   1);    // pause while output stuck
        repeat (3)  cycle(100, 4'hF,   4'hF, 100, 1);    // drains, then idle with ack
        repeat (4)  cycle(100, 4'hF,   4'hF, 100, 0);    // resume
        repeat (200) cycle(60, 4'hF,   -1,   75,  2);
        do_reset();
        repeat (150) cycle(60, 4'hF,   -1,   75,  2);

        guard = 0;
        while ((exp_qid.size() != 0 || src_vld[0] || src_vld[1] || src_vld[2] || src_vld[3]) && guard < 60) begin
            cycle(0, 4'h0, 4'hF, 100, 0);
            guard++;
        end
        cycle(0, 4'h0, 4'hF, 100, 0);
        chk("drain_complete", exp_qid.size(), 0);
`ifdef PHV_SCHED_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*32 +: 32], 32'(m_cnt[i]));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
